wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the register file's single write port between NUM_REQ writeback sources (e.g. 0 = ALU, 1 = LSU, 2 = mul/div).
- Uses round-robin arbitration and drives a registered write (we/waddr/wdata) into regfile.
- Keeps a per-register busy scoreboard: issue sets a bit, an accepted writeback clears it. The decode stage uses the busy outputs to stall reads of registers whose writes are still pending.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8)
- DATA_W, 32, register data width (matches RegBus)
- ADDR_W, 5, register address width (matches RegAddrBus); register count = 2**ADDR_W

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  requester i has a write pending
- req_waddr  in  NUM_REQ*ADDR_W  packed destination addresses; requester i at bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data; requester i at bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot grant, combinational; transfer occurs when valid&ready at a clock edge
- we  out  1  regfile write enable (registered)
- waddr  out  ADDR_W  regfile write address (registered)
- wdata  out  DATA_W  regfile write data (registered)
- issue_set  in  1  decode issued an instruction that writes issue_addr
- issue_addr  in  ADDR_W  destination being marked busy
- flush  in  1  pipeline flush: clear all busy bits
- rs1_addr  in  ADDR_W  query address 1
- rs2_addr  in  ADDR_W  query address 2
- rs1_busy  out  1  busy[rs1_addr], combinational; always 0 for address 0
- rs2_busy  out  1  busy[rs2_addr], combinational; always 0 for address 0

Behaviour:
- Reset (rst = 1 at an edge):
  - we = 0, waddr = 0, wdata = 0.
  - All busy bits cleared; round-robin pointer reset so requester 0 has top priority.
  - req_ready is forced to all 0 while rst = 1.
- Arbitration (combinational):
  - Among the asserted req_valid bits, grant the first index found scanning from ptr+1 upward, modulo NUM_REQ.
  - ptr = index of the last granted requester; it updates only on a grant.
  - At most one req_ready bit is high; no grant is given without valid.
- Requester rules:
  - A requester holds valid, waddr and wdata stable until it sees ready.
  - Ready may drop in any cycle where another requester wins.
- Write stage:
  - On the edge after the grant: we = 1, waddr/wdata = the granted request, for exactly one cycle.
  - With no grant: we = 0 and waddr/wdata hold their previous values.
  - Latency: accepted at the edge ending cycle N, we asserted in N+1, value in regs after the edge ending N+1.
  - The regfile's same-cycle bypass covers reads during N+1.
- x0 writes: a grant with waddr = 0 is consumed (ready = 1) but produces we = 0 in the next cycle.
- Throughput: one write per cycle. With all requesters valid continuously, grants rotate 0,1,2,0,... with no starvation; the maximum wait is NUM_REQ-1 cycles.
- Busy scoreboard (2**ADDR_W bits):
  - Bit 0 is never set.
  - Edge with issue_set: busy[issue_addr] <= 1.
  - Edge with an accepted grant: busy[granted waddr] <= 0 (cleared at acceptance, so busy is already low in N+1 when the bypass supplies the data).
  - Set and clear to the same address at the same edge: set wins (newer producer).
  - flush: clears all bits and overrides issue_set that edge. In-flight grants and the write stage are not cancelled.
  - rst overrides everything.
- Widths: all packing is fixed; no arithmetic beyond the modulo-NUM_REQ pointer scan.

Decomposition:
- Shared defines header (existing style): RstEnable, WriteEnable, ZeroWord, RegAddrBus, RegBus, RegNumLog2.
- No new typedefs.
- One sub-module: rr_arbiter (NUM_REQ valid in, one-hot grant out, pointer register inside, advance input).
- The scoreboard and write register stay in the top level.

Test Plan:
- Reset: assert rst for 2 cycles with all inputs active -> req_ready = 0, we = 0, rs1_busy = rs2_busy = 0. After release with req_valid = 3'b111 -> first grant to requester 0.
- Rotation: all 3 valid for 6 cycles, addrs 1/2/3, data A/B/C -> we pulses with waddr 1,2,3,1,2,3 and matching data; each lands one cycle after the grant.
- Single requester: only LSU valid, waddr = 7, wdata = 0xDEADBEEF -> ready same cycle; next cycle we = 1, waddr = 7, wdata = 0xDEADBEEF; the cycle after, we = 0.
- x0 write: ALU valid with waddr = 0 -> ready = 1, next cycle we = 0; busy[0] stays 0.
- Scoreboard: issue_set to x5, then rs1_addr = 5 -> rs1_busy = 1. Grant a write to x5 -> rs1_busy = 0 the cycle after acceptance. issue_set x5 together with an accepted write to x5 -> busy stays 1.
- Flush: mark x3 and x9 busy, assert flush with issue_set x4 -> x3, x9 and x4 all read 0. A pending grant in the same cycle still produces its we pulse.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared register-bus widths and control encodings
package wb_port_arbiter_pkg;
  localparam logic rst_enable = 1'b1;
  localparam logic write_enable = 1'b1;
  localparam int reg_bus_w = 32;
  localparam int reg_num_log2 = 5;
  localparam int reg_addr_w = reg_num_log2;
  localparam logic [reg_bus_w-1:0] zero_word = '0;
endpackage

// File: rtl/wb_port_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant, scanning upward from the last winner
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] valid,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic found;
  // first valid index after ptr wins; nothing is granted during reset
  always_comb begin
    grant = '0;
    gidx = ptr;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && valid[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        grant[(int'(ptr) + k) % N] = 1'b1;
        gidx = PW'((int'(ptr) + k) % N);
      end
    end
    if (rst) grant = '0;
  end
  // ptr starts at N-1 so requester 0 leads after reset
  always_ff @(posedge clk) begin
    if (rst) ptr <= PW'(N - 1);
    else if (advance && found) ptr <= gidx;
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the regfile write port and tracks pending-write busy bits
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W = reg_bus_w,
  parameter int ADDR_W = reg_addr_w
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_waddr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      we,
  output logic [ADDR_W-1:0]         waddr,
  output logic [DATA_W-1:0]         wdata,
  input  logic                      issue_set,
  input  logic [ADDR_W-1:0]         issue_addr,
  input  logic                      flush,
  input  logic [ADDR_W-1:0]         rs1_addr,
  input  logic [ADDR_W-1:0]         rs2_addr,
  output logic                      rs1_busy,
  output logic                      rs2_busy
);
  logic accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [2**ADDR_W-1:0] busy;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk(clk),
    .rst(rst),
    .valid(req_valid),
    .advance(accept),
    .grant(req_ready)
  );
  assign accept = |req_ready;
  // one-hot mux of the winning request
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_addr = sel_addr | (req_ready[i] ? req_waddr[i*ADDR_W +: ADDR_W] : '0);
      sel_data = sel_data | (req_ready[i] ? req_wdata[i*DATA_W +: DATA_W] : '0);
    end
  end
  // registered write port; x0 grants are consumed without a write
  always_ff @(posedge clk) begin
    if (rst == rst_enable) begin
      we <= ~write_enable;
      waddr <= '0;
      wdata <= zero_word[DATA_W-1:0];
    end else begin
      we <= (accept && sel_addr != '0) ? write_enable : ~write_enable;
      if (accept) begin
        waddr <= sel_addr;
        wdata <= sel_data;
      end
    end
  end
  // busy scoreboard: clear at acceptance, later set wins, flush clears all
  always_ff @(posedge clk) begin
    if (rst || flush) busy <= '0;
    else begin
      if (accept) busy[sel_addr] <= 1'b0;
      if (issue_set && issue_addr != '0) busy[issue_addr] <= 1'b1;
    end
  end
  assign rs1_busy = busy[rs1_addr];
  assign rs2_busy = busy[rs2_addr];
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed checks of arbitration, write stage and scoreboard
module tb_wb_port_arbiter;
  localparam int N = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  logic clk = 0;
  logic rst;
  logic [N-1:0] req_valid;
  logic [N*AW-1:0] req_waddr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0] req_ready;
  logic we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic issue_set;
  logic [AW-1:0] issue_addr;
  logic flush;
  logic [AW-1:0] rs1_addr, rs2_addr;
  logic rs1_busy, rs2_busy;
  int errors = 0;
  int checks = 0;
  logic [N-1:0] exp_g [6];
  logic [AW-1:0] exp_a [6];
  logic [DW-1:0] exp_d [6];

  always #5 clk = ~clk;

  wb_port_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_waddr(req_waddr),
    .req_wdata(req_wdata), .req_ready(req_ready), .we(we), .waddr(waddr),
    .wdata(wdata), .issue_set(issue_set), .issue_addr(issue_addr),
    .flush(flush), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_waddr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    rst = 1; req_valid = 3'b111; req_waddr = '0; req_wdata = '0;
    issue_set = 1; issue_addr = 5; flush = 1; rs1_addr = 5; rs2_addr = 5;
    set_req(0, 1, 32'hAAAA_0001);
    set_req(1, 2, 32'hBBBB_0002);
    set_req(2, 3, 32'hCCCC_0003);
    step();
    flush = 0;
    step();
    chk("rst_ready", req_ready, 0);
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_rs1_busy", rs1_busy, 0);
    chk("rst_rs2_busy", rs2_busy, 0);
    rst = 0; issue_set = 0;
    #1;
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_a = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
    exp_d = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003,
              32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rot_grant%0d", i), req_ready, exp_g[i]);
      step();
      chk($sformatf("rot_we%0d", i), we, 1);
      chk($sformatf("rot_waddr%0d", i), waddr, exp_a[i]);
      chk($sformatf("rot_wdata%0d", i), wdata, exp_d[i]);
    end
    req_valid = 3'b010;
    set_req(1, 7, 32'hDEAD_BEEF);
    #1;
    chk("single_ready", req_ready, 3'b010);
    step();
    req_valid = 0;
    #1;
    chk("single_we", we, 1);
    chk("single_waddr", waddr, 7);
    chk("single_wdata", wdata, 32'hDEAD_BEEF);
    chk("idle_ready", req_ready, 0);
    step();
    chk("single_we_drop", we, 0);
    chk("single_waddr_hold", waddr, 7);
    chk("single_wdata_hold", wdata, 32'hDEAD_BEEF);
    req_valid = 3'b001;
    set_req(0, 0, 32'h1234_5678);
    #1;
    chk("x0_ready", req_ready, 3'b001);
    step();
    req_valid = 0; rs1_addr = 0;
    #1;
    chk("x0_we", we, 0);
    chk("x0_busy", rs1_busy, 0);
    issue_set = 1; issue_addr = 5;
    step();
    issue_set = 0; rs1_addr = 5; rs2_addr = 6;
    #1;
    chk("sb_set_x5", rs1_busy, 1);
    chk("sb_x6_clear", rs2_busy, 0);
    req_valid = 3'b001;
    set_req(0, 5, 32'h0000_0555);
    #1;
    chk("sb_wr_ready", req_ready, 3'b001);
    step();
    req_valid = 0;
    #1;
    chk("sb_clr_x5", rs1_busy, 0);
    chk("sb_wr_we", we, 1);
    chk("sb_wr_waddr", waddr, 5);
    issue_set = 1; issue_addr = 5;
    req_valid = 3'b010;
    set_req(1, 5, 32'h0000_0AAA);
    #1;
    chk("sb_race_ready", req_ready, 3'b010);
    step();
    issue_set = 0; req_valid = 0;
    #1;
    chk("sb_set_wins", rs1_busy, 1);
    issue_set = 1; issue_addr = 3;
    step();
    issue_addr = 9;
    step();
    rs1_addr = 3; rs2_addr = 9;
    #1;
    chk("fl_pre_x3", rs1_busy, 1);
    chk("fl_pre_x9", rs2_busy, 1);
    flush = 1; issue_addr = 4;
    req_valid = 3'b100;
    set_req(2, 12, 32'h0000_0C0C);
    #1;
    chk("fl_ready", req_ready, 3'b100);
    step();
    flush = 0; issue_set = 0; req_valid = 0;
    #1;
    chk("fl_x3", rs1_busy, 0);
    chk("fl_x9", rs2_busy, 0);
    chk("fl_we", we, 1);
    chk("fl_waddr", waddr, 12);
    chk("fl_wdata", wdata, 32'h0000_0C0C);
    rs1_addr = 4; rs2_addr = 5;
    #1;
    chk("fl_x4", rs1_busy, 0);
    chk("fl_x5", rs2_busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
